// File: rtl/fme_ref_fetch_if.sv
// Bus bundle between the reference fetch stage, the search-window SRAM
// read port and the FME line RAM write port.
//
// Handshake: the SRAM read is fire-and-forget, ref_data_i is valid exactly
// one cycle after ref_rden_o. The FME RAM write transfers a line in every
// cycle wren_o is high; wren_o only rises while ft_go_ahead_i=1 and full_i=0.
interface fme_ref_fetch_if #(
    parameter int BIT_DEPTH = 8,
    parameter int REF_W     = 32,
    parameter int ADDR_W    = 7
);
    logic                          ref_rden_o;
    logic [ADDR_W-1:0]             ref_addr_o;
    logic [REF_W*BIT_DEPTH-1:0]    ref_data_i;
    logic [20*BIT_DEPTH-1:0]       data_o;
    logic                          wren_o;
    logic                          ft_go_ahead_i;
    logic                          full_i;

    // Fetch stage side.
    modport master (
        output ref_rden_o, ref_addr_o, data_o, wren_o,
        input  ref_data_i, ft_go_ahead_i, full_i
    );

    // SRAM / FME RAM side.
    modport slave (
        input  ref_rden_o, ref_addr_o, data_o, wren_o,
        output ref_data_i, ft_go_ahead_i, full_i
    );
endinterface

// File: rtl/fme_ref_fetch.sv
// Fractional-ME reference fetch: reads N rows of the search-window SRAM,
// cuts a 20-pixel window at a horizontal offset out of each row and writes
// it as one line into the FME RAM through a 2-entry buffer.
// Optional build macro: FME_REF_FETCH_VCLAMP_EN clamps row addresses to
// [row_min_i, row_max_i] (picture edge row replication).
module fme_ref_fetch #(
    parameter int BIT_DEPTH = 8,
    parameter int REF_W     = 32,
    parameter int ADDR_W    = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fme_ref_fetch_if.master    bus,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_row_i,
    input  logic [5:0]         lines_i,
    input  logic [4:0]         x_ofs_i,
`ifdef FME_REF_FETCH_VCLAMP_EN
    input  logic [ADDR_W-1:0]  row_min_i,
    input  logic [ADDR_W-1:0]  row_max_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         dbg_state_o
);
    localparam int RW      = REF_W * BIT_DEPTH;
    localparam int LW      = 20 * BIT_DEPTH;
    localparam int IW      = $clog2(RW);
    localparam int MAX_OFS = REF_W - 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [5:0]        r_lines;
    logic [4:0]        r_xofs;
    logic [5:0]        r_issued;
    logic              r_pend;
    logic [LW-1:0]     r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;
`ifdef FME_REF_FETCH_VCLAMP_EN
    logic [ADDR_W-1:0] r_row_min;
    logic [ADDR_W-1:0] r_row_max;
`endif

    logic              w_can_wr;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_rden;
    logic [ADDR_W-1:0] w_addr_raw;
    logic [ADDR_W-1:0] w_addr;
    logic [4:0]        w_xofs_clamp;
    logic [IW-1:0]     w_win_lsb;
    logic [LW-1:0]     w_win;

    // Flow control, read issue, address generation and window extraction.
    always_comb begin
        w_can_wr     = bus.ft_go_ahead_i & ~bus.full_i;
        w_pop        = (r_cnt != 2'd0) & w_can_wr;
        // Lines that will still be held after this cycle, counting the
        // read now returning; a new read is only issued if it will fit.
        w_occ        = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
        w_rden       = (r_state == S_FETCH) && (r_issued != r_lines) && (w_occ < 3'd2);
        w_addr_raw   = r_base + ADDR_W'(r_issued);
        w_addr       = w_addr_raw;
`ifdef FME_REF_FETCH_VCLAMP_EN
        if (w_addr_raw < r_row_min) begin
            w_addr = r_row_min;
        end else if (w_addr_raw > r_row_max) begin
            w_addr = r_row_max;
        end
`endif
        w_xofs_clamp = (int'(x_ofs_i) > MAX_OFS) ? 5'(MAX_OFS) : x_ofs_i;
        w_win_lsb    = IW'(RW - LW - int'(r_xofs) * BIT_DEPTH);
        w_win        = bus.ref_data_i[w_win_lsb +: LW];
    end

    assign bus.ref_rden_o = w_rden;
    assign bus.ref_addr_o = w_rden ? w_addr : '0;
    assign bus.wren_o     = w_pop;
    assign bus.data_o     = r_mem[r_rptr];
    assign busy_o         = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done_o         = (r_state == S_DONE);
    assign dbg_state_o    = r_state;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; DRAIN leaves as soon as this cycle empties everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_FETCH;
            S_FETCH: if (r_issued == r_lines) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_occ == 3'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Job registers, read counter, return flag and the 2-entry line buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_base   <= '0;
            r_lines  <= '0;
            r_xofs   <= '0;
            r_issued <= '0;
            r_pend   <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= '0;
`ifdef FME_REF_FETCH_VCLAMP_EN
            r_row_min <= '0;
            r_row_max <= '0;
`endif
        end else if (clear_i) begin
            // Dropping r_pend discards the read returning next cycle.
            r_base   <= '0;
            r_lines  <= '0;
            r_xofs   <= '0;
            r_issued <= '0;
            r_pend   <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= '0;
`ifdef FME_REF_FETCH_VCLAMP_EN
            r_row_min <= '0;
            r_row_max <= '0;
`endif
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_base   <= base_row_i;
                r_lines  <= (lines_i == 6'd0) ? 6'd32 : lines_i;
                r_xofs   <= w_xofs_clamp;
                r_issued <= '0;
`ifdef FME_REF_FETCH_VCLAMP_EN
                r_row_min <= row_min_i;
                r_row_max <= row_max_i;
`endif
            end else if (w_rden) begin
                r_issued <= r_issued + 6'd1;
            end
            r_pend <= w_rden;
            if (r_pend) begin
                r_mem[r_wptr] <= w_win;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_fme_ref_fetch.sv
// Directed bench for fme_ref_fetch: SRAM row model, cycle-exact latency,
// window offsets, backpressure, address wrap, aborts and start filtering.
module tb_fme_ref_fetch;
    localparam int BD     = 8;
    localparam int REF_W  = 32;
    localparam int ADDR_W = 7;
    localparam int LW     = 20 * BD;
    localparam int RW     = REF_W * BD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_row = '0;
    logic [5:0]        lines = '0;
    logic [4:0]        x_ofs = '0;
`ifdef FME_REF_FETCH_VCLAMP_EN
    logic [ADDR_W-1:0] row_min = '0;
    logic [ADDR_W-1:0] row_max = 7'd127;
`endif
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [LW-1:0]     exp_q[$];

    fme_ref_fetch_if #(.BIT_DEPTH(BD), .REF_W(REF_W), .ADDR_W(ADDR_W)) bus ();

    fme_ref_fetch #(.BIT_DEPTH(BD), .REF_W(REF_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .clear_i     (clear),
        .start_i     (start),
        .base_row_i  (base_row),
        .lines_i     (lines),
        .x_ofs_i     (x_ofs),
`ifdef FME_REF_FETCH_VCLAMP_EN
        .row_min_i   (row_min),
        .row_max_i   (row_max),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int r, input int p);
        return 8'((r * 5 + p * 11 + 3) & 255);
    endfunction

    function automatic logic [RW-1:0] make_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int p = 0; p < REF_W; p++) v[(REF_W-1-p)*BD +: BD] = pix(r, p);
        return v;
    endfunction

    function automatic logic [LW-1:0] make_line(input int r, input int x);
        logic [LW-1:0] v;
        v = '0;
        for (int j = 0; j < 20; j++) v[(19-j)*BD +: BD] = pix(r, x + j);
        return v;
    endfunction

    // Search-window SRAM: data one cycle after the read enable.
    always @(posedge clk) begin
        if (bus.ref_rden_o) bus.ref_data_i <= make_row(int'(bus.ref_addr_o));
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_linear(input int base, input int n);
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) exp_addr_q.push_back(ADDR_W'(base + i));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " state"}, int'(dbg_state), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " wren"}, int'(bus.wren_o), 0);
        check({tag, " rden"}, int'(bus.ref_rden_o), 0);
    endtask

    // One full job; exp_addr_q must already hold the expected row addresses.
    task automatic run_xfer(input string tag, input int base, input int lines_in, input int x_in,
                            input int x_eff, input int stall_at, input int stall_len,
                            input bit stall_full, input int restart_at, input int exp_done);
        int n_exp, cyc, reads, writes, max_out, gate_bad, first_rd, first_wr, done_cyc;
        logic [ADDR_W-1:0] a;
        n_exp = exp_addr_q.size();
        exp_q.delete();
        reads = 0; writes = 0; max_out = 0; gate_bad = 0;
        first_rd = -1; first_wr = -1; done_cyc = -1;
        base_row = ADDR_W'(base); lines = 6'(lines_in); x_ofs = 5'(x_in);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc <= 300) begin
            if (cyc >= stall_at && cyc < stall_at + stall_len) begin
                bus.ft_go_ahead_i = !stall_full;
                bus.full_i        = stall_full;
            end else begin
                bus.ft_go_ahead_i = 1'b1;
                bus.full_i        = 1'b0;
            end
            if (cyc == restart_at) begin
                start = 1'b1; base_row = ADDR_W'(base + 50);
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 1) check({tag, " busy_at_T+1"}, int'(busy), 1);
            if (bus.ref_rden_o) begin
                reads++;
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr_q.size() != 0) begin
                    a = exp_addr_q.pop_front();
                    check({tag, " addr"}, int'(bus.ref_addr_o), int'(a));
                    exp_q.push_back(make_line(int'(a), x_eff));
                end
            end
            if (bus.wren_o) begin
                writes++;
                if (first_wr < 0) first_wr = cyc;
                if (!(bus.ft_go_ahead_i && !bus.full_i)) gate_bad++;
                if (exp_q.size() != 0) check_line({tag, " data"}, bus.data_o, exp_q.pop_front());
            end
            if (reads - writes > max_out) max_out = reads - writes;
            if (done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.ft_go_ahead_i = 1'b1;
        bus.full_i = 1'b0;
        check({tag, " done_seen"}, int'(done_cyc > 0), 1);
        check({tag, " reads"}, reads, n_exp);
        check({tag, " writes"}, writes, n_exp);
        check({tag, " max_buffered"}, int'(max_out <= 2), 1);
        check({tag, " wren_while_blocked"}, gate_bad, 0);
        check({tag, " first_rd"}, first_rd, 1);
        check({tag, " first_wr"}, first_wr, 3);
        if (exp_done > 0) check({tag, " done_cycle"}, done_cyc, exp_done);
        #1;
        check_idle({tag, " after_done"});
    endtask

    // Starts a job and follows its reads up to cycle stop_cyc (no stalls).
    task automatic start_partial(input string tag, input int base, input int n, input int stop_cyc);
        base_row = ADDR_W'(base); lines = 6'(n); x_ofs = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= stop_cyc; c++) begin
            #1;
            check({tag, " rden"}, int'(bus.ref_rden_o), 1);
            check({tag, " addr"}, int'(bus.ref_addr_o), (base + c - 1) % 128);
            check({tag, " done"}, int'(done), 0);
            if (c < stop_cyc) @(negedge clk);
        end
    endtask

    initial begin
        bus.ft_go_ahead_i = 1'b1;
        bus.full_i        = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle("reset");
        check("reset addr", int'(bus.ref_addr_o), 0);
        check_line("reset data", bus.data_o, '0);
        @(negedge clk);
        rst = 1'b0;

        fill_linear(10, 21);
        run_xfer("basic", 10, 21, 0, 0, 0, 0, 1'b0, -1, 24);

        fill_linear(33, 3);
        run_xfer("ofs7", 33, 3, 7, 7, 0, 0, 1'b0, -1, 6);

        fill_linear(50, 2);
        run_xfer("ofs20_clamp", 50, 2, 20, 12, 0, 0, 1'b0, -1, 5);

        fill_linear(5, 2);
        run_xfer("ofs31_clamp", 5, 2, 31, 12, 0, 0, 1'b0, -1, 5);

        fill_linear(10, 21);
        run_xfer("stall_go", 10, 21, 0, 0, 8, 5, 1'b0, -1, -1);

        fill_linear(60, 6);
        run_xfer("stall_full", 60, 6, 3, 3, 4, 3, 1'b1, -1, -1);

        fill_linear(120, 16);
        run_xfer("wrap", 120, 16, 0, 0, 0, 0, 1'b0, -1, 19);

        fill_linear(0, 32);
        run_xfer("lines0", 0, 0, 4, 4, 0, 0, 1'b0, -1, 35);

        fill_linear(20, 5);
        run_xfer("start_ignored", 20, 5, 0, 0, 0, 0, 1'b0, 3, 8);

        start_partial("clr_pre", 40, 20, 9);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_idle("clear");
        fill_linear(70, 3);
        run_xfer("after_clear", 70, 3, 0, 0, 0, 0, 1'b0, -1, 6);

        start_partial("rst_pre", 90, 12, 6);
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        check("rst_mid addr", int'(bus.ref_addr_o), 0);
        check_line("rst_mid data", bus.data_o, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_release");
        fill_linear(100, 4);
        run_xfer("after_rst", 100, 4, 0, 0, 0, 0, 1'b0, -1, 7);

        start = 1'b1; clear = 1'b1; base_row = 7'd3; lines = 6'd2;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        #1;
        check_idle("clear_over_start");
        @(negedge clk);
        #1;
        check_idle("clear_over_start_2");

`ifdef FME_REF_FETCH_VCLAMP_EN
        row_min = 7'd4; row_max = 7'd7;
        exp_addr_q.delete();
        exp_addr_q.push_back(7'd4); exp_addr_q.push_back(7'd4);
        exp_addr_q.push_back(7'd4); exp_addr_q.push_back(7'd5);
        exp_addr_q.push_back(7'd6); exp_addr_q.push_back(7'd7);
        exp_addr_q.push_back(7'd7); exp_addr_q.push_back(7'd7);
        run_xfer("vclamp", 2, 8, 0, 0, 0, 0, 1'b0, -1, 11);
        row_min = '0; row_max = 7'd127;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
